wallace_mac_acc: RTL and testbench

Sequential accumulate stage sitting directly downstream of `wallace_16bit`. It takes the 32-bit unsigned product `Z` from the multiplier, one per valid/ready handshake, and sums a fixed-length window of `COUNT` products into a saturating accumulator. It presents the window total on a valid/ready output port and holds it until the consumer takes it. This turns the combinational multiplier into a multiply-accumulate datapath for dot-product style workloads.

---
 rtl/wallace_mac_acc.sv | 126 ++++++++++++
 tb/tb_wallace_mac_acc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac_acc.sv
// wallace_mac_acc
// Accumulates a fixed window of COUNT unsigned 32-bit products (from
// wallace_16bit.Z) into a saturating ACC_W-bit sum and presents the window
// total on a valid/ready output. It holds that total until the consumer
// takes it.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 synchronous clear of the current window / pending result
//   z_in-side:  Z_in, in_valid, in_ready   product input handshake
//   out-side:   acc_out, ovf, out_valid, out_ready   window result handshake
module wallace_mac_acc #(
    parameter int ACC_W = 40,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [31:0]      Z_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] LAST = 8'(COUNT - 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             sat, sat_nxt;
    logic [ACC_W-1:0] acc_out_q, acc_out_nxt;
    logic             ovf_q, ovf_nxt;
    logic             out_valid_q, out_valid_nxt;

    // One extra bit on the adder so the carry-out is the overflow flag.
    logic [ACC_W:0]   sum;
    logic             step_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             accept;

    assign sum      = {1'b0, acc} + {{(ACC_W-31){1'b0}}, Z_in};
    assign step_ovf = sum[ACC_W];
    assign sum_sat  = step_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    // in_ready decodes the state register only, so no combinational path
    // runs from in_valid or out_ready.
    assign in_ready  = (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            sat         <= sat_nxt;
            acc_out_q   <= acc_out_nxt;
            ovf_q       <= ovf_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        sat_nxt       = sat;
        acc_out_nxt   = acc_out_q;
        ovf_nxt       = ovf_q;
        out_valid_nxt = out_valid_q;

        if (clr) begin
            // A product offered in the same cycle is dropped. acc_out keeps
            // its stale value because it is only meaningful with out_valid.
            state_nxt     = ACCUM;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            sat_nxt       = 1'b0;
            ovf_nxt       = 1'b0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            acc_out_nxt   = sum_sat;
                            ovf_nxt       = sat | step_ovf;
                            out_valid_nxt = 1'b1;
                            acc_nxt       = '0;
                            cnt_nxt       = '0;
                            sat_nxt       = 1'b0;
                            state_nxt     = HOLD;
                        end else begin
                            acc_nxt = sum_sat;
                            cnt_nxt = cnt + 8'd1;
                            sat_nxt = sat | step_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = ACCUM;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mac_acc.sv
module tb_wallace_mac_acc;

    typedef struct {
        logic [63:0] acc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] Z_in = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready40, out_valid40, ovf40;
    logic [39:0] acc_out40;
    logic        in_ready33, out_valid33, ovf33;
    logic [32:0] acc_out33;

    int tests = 0;
    int fails = 0;
    exp_t q40[$];
    exp_t q33[$];

    always #5 clk = ~clk;

    wallace_mac_acc #(.ACC_W(40), .COUNT(4)) dut40 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .Z_in(Z_in), .in_valid(in_valid),
        .in_ready(in_ready40), .acc_out(acc_out40), .out_valid(out_valid40),
        .out_ready(out_ready), .ovf(ovf40)
    );

    wallace_mac_acc #(.ACC_W(33), .COUNT(4)) dut33 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .Z_in(Z_in), .in_valid(in_valid),
        .in_ready(in_ready33), .acc_out(acc_out33), .out_valid(out_valid33),
        .out_ready(out_ready), .ovf(ovf33)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [63:0] a40, input logic o40,
                        input logic [63:0] a33, input logic o33);
        exp_t e;
        e.acc = a40; e.ovf = o40; q40.push_back(e);
        e.acc = a33; e.ovf = o33; q33.push_back(e);
    endtask

    // Called #1 after an edge with this cycle's inputs already driven:
    // scores any output handshake that the coming edge will complete.
    task automatic cycle();
        exp_t e;
        if (out_valid40 && out_ready) begin
            if (q40.size() == 0) chk("unexpected_out40", 64'(q40.size()), 64'd1);
            else begin
                e = q40.pop_front();
                chk("acc_out40", 64'(acc_out40), e.acc);
                chk("ovf40", 64'(ovf40), 64'(e.ovf));
            end
        end
        if (out_valid33 && out_ready) begin
            if (q33.size() == 0) chk("unexpected_out33", 64'(q33.size()), 64'd1);
            else begin
                e = q33.pop_front();
                chk("acc_out33", 64'(acc_out33), e.acc);
                chk("ovf33", 64'(ovf33), 64'(e.ovf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] z);
        chk("in_ready_send", 64'(in_ready40), 64'd1);
        in_valid = 1'b1;
        Z_in     = z;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_acc_out", 64'(acc_out40), 64'd0);
        chk("rst_out_valid", 64'(out_valid40), 64'd0);
        chk("rst_ovf", 64'(ovf40), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready40), 64'd1);

        // Back-to-back window of 81s
        push(324, 0, 324, 0);
        for (int i = 0; i < 4; i++) send(81);
        chk("lat_t1", 64'(out_valid40), 64'd1);
        cycle();
        chk("one_cycle_t1", 64'(out_valid40), 64'd0);

        // Bubbles between the 2nd and 3rd products
        push(324, 0, 324, 0);
        send(81); send(81);
        idle(3);
        chk("no_early_out", 64'(out_valid40), 64'd0);
        send(81); send(81);
        chk("lat_t2", 64'(out_valid40), 64'd1);
        cycle();

        // Backpressure hold
        out_ready = 1'b0;
        push(100, 0, 100, 0);
        send(10); send(20); send(30); send(40);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            Z_in     = 32'd999;
            chk("hold_in_ready", 64'(in_ready40), 64'd0);
            chk("hold_acc_out", 64'(acc_out40), 64'd100);
            chk("hold_out_valid", 64'(out_valid40), 64'd1);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("release_out_valid", 64'(out_valid40), 64'd0);
        chk("release_in_ready", 64'(in_ready40), 64'd1);

        // Saturation in the 33-bit instance, then a clean window
        push(64'h3_FFFF_FFFC, 0, 64'h1_FFFF_FFFF, 1);
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
        cycle();
        push(4, 0, 4, 0);
        for (int i = 0; i < 4; i++) send(1);
        cycle();

        // clr discards partial window and same-cycle product
        send(500); send(600);
        clr = 1'b1; in_valid = 1'b1; Z_in = 32'd7;
        cycle();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", 64'(out_valid40), 64'd0);
        push(10, 0, 10, 0);
        send(1); send(2); send(3); send(4);
        cycle();

        // clr during HOLD drops the pending result
        out_ready = 1'b0;
        send(9); send(9); send(9); send(9);
        chk("pre_clr_hold", 64'(out_valid40), 64'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        out_ready = 1'b1;
        chk("clr_hold_out_valid", 64'(out_valid40), 64'd0);
        chk("clr_hold_in_ready", 64'(in_ready40), 64'd1);

        // Async reset mid-window
        send(2); send(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid40), 64'd0);
        chk("async_acc_out", 64'(acc_out40), 64'd0);
        chk("async_acc_out33", 64'(acc_out33), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(20, 0, 20, 0);
        for (int i = 0; i < 4; i++) send(5);
        chk("lat_post_rst", 64'(out_valid40), 64'd1);
        cycle();

        chk("scoreboard_drained40", 64'(q40.size()), 64'd0);
        chk("scoreboard_drained33", 64'(q33.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
